spi_flash_read_master: RTL

// - SPI mode-0 master that fetches one 32-bit little-endian word from the serial boot flash per request.
// - Sits between the mem_space ROM path and the flash pins (flash_csn/clk/mosi/miso/wpn/holdn).
// - Pairs with sim_flash_slave in simulation and with the board flash in hardware.

---
 rtl/spi_flash_read_master_if.sv | 13 +
 rtl/spi_flash_read_master.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/spi_flash_read_master_if.sv
// Request/response bus between the ROM fetch path and the SPI flash read master.
interface spi_flash_read_master_if #(
   parameter int ADDR_WIDTH = 24
);
   logic                  stb_i;
   logic [ADDR_WIDTH-1:0] addr_i;
   logic                  busy_o;
   logic                  ack_o;
   logic [31:0]           data_o;

   modport master (output stb_i, output addr_i, input busy_o, input ack_o, input data_o);
   modport slave  (input stb_i, input addr_i, output busy_o, output ack_o, output data_o);
endinterface

// File: rtl/spi_flash_read_master.sv
// SPI mode-0 master fetching one little-endian 32-bit word from the boot flash per request.
// Define FLASH_FAST_READ_EN to use command 0x0B with 8 dummy clocks instead of plain READ 0x03.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | csn high, waiting for stb_i
// ST_CMD    | shifting out the 8-bit command
// ST_ADDR   | shifting out the 24-bit address, MSB first
// ST_DUMMY  | 8 dummy clocks, mosi low (fast read only)
// ST_DATA   | 32 clocks capturing miso on flash_clk rising edges
// ST_DONE   | csn high, ack_o pulse, data_o updated
// ST_CS_GAP | csn held high for the remaining recovery cycles
module spi_flash_read_master #(
   parameter int CLK_DIV        = 1,
   parameter int CS_HIGH_CYCLES = 4,
   parameter int ADDR_WIDTH     = 24
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   spi_flash_read_master_if.slave   bus,
   output logic                     flash_csn,
   output logic                     flash_clk,
   output logic                     flash_mosi,
   input  logic                     flash_miso,
   output logic                     flash_wpn,
   output logic                     flash_holdn
);

   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int GAP_W = $clog2(CS_HIGH_CYCLES + 1);
   localparam int TX_W  = 8 + ADDR_WIDTH;

   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((CS_HIGH_CYCLES > 1) ? CS_HIGH_CYCLES - 2 : 0);

`ifdef FLASH_FAST_READ_EN
   localparam logic [7:0] CMD = 8'h0B;
`else
   localparam logic [7:0] CMD = 8'h03;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA,
      ST_DONE,
      ST_CS_GAP
   } state_t;

   state_t            state;
   logic [6:0]        bit_cnt;
   logic [DIV_W-1:0]  div_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [TX_W-1:0]   tx_sr;
   logic [31:0]       rx_sr;
   logic              busy_r;
   logic              ack_r;
   logic [31:0]       data_r;
   logic              div_tc;

   assign bus.busy_o  = busy_r;
   assign bus.ack_o   = ack_r;
   assign bus.data_o  = data_r;
   assign flash_wpn   = 1'b1;
   assign flash_holdn = 1'b1;

   assign div_tc = (div_cnt == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         div_cnt    <= '0;
         gap_cnt    <= '0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         busy_r     <= 1'b0;
         ack_r      <= 1'b0;
         data_r     <= '0;
         flash_csn  <= 1'b1;
         flash_clk  <= 1'b0;
         flash_mosi <= 1'b0;
      end else begin
         ack_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.stb_i) begin
                  state      <= ST_CMD;
                  busy_r     <= 1'b1;
                  flash_csn  <= 1'b0;
                  flash_clk  <= 1'b0;
                  flash_mosi <= CMD[7];
                  // tx_sr holds the bits still to go, already one ahead of mosi
                  tx_sr      <= {CMD[6:0], bus.addr_i, 1'b0};
                  bit_cnt    <= 7'd7;
                  div_cnt    <= DIV_LOAD;
               end
            end

            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
               if (!div_tc) begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end else begin
                  div_cnt <= DIV_LOAD;
                  if (!flash_clk) begin
                     flash_clk <= 1'b1;
                     if (state == ST_DATA)
                        rx_sr <= {rx_sr[30:0], flash_miso};
                  end else begin
                     // end of bit cell: next low phase starts with the next mosi bit
                     flash_clk  <= 1'b0;
                     flash_mosi <= 1'b0;
                     tx_sr      <= {tx_sr[TX_W-2:0], 1'b0};
                     if (bit_cnt != 7'd0) begin
                        bit_cnt <= bit_cnt - 7'd1;
                        if (state == ST_CMD || state == ST_ADDR)
                           flash_mosi <= tx_sr[TX_W-1];
                     end else begin
                        case (state)
                           ST_CMD: begin
                              state      <= ST_ADDR;
                              bit_cnt    <= 7'(ADDR_WIDTH - 1);
                              flash_mosi <= tx_sr[TX_W-1];
                           end
                           ST_ADDR: begin
`ifdef FLASH_FAST_READ_EN
                              state   <= ST_DUMMY;
                              bit_cnt <= 7'd7;
`else
                              state   <= ST_DATA;
                              bit_cnt <= 7'd31;
`endif
                           end
                           ST_DUMMY: begin
                              state   <= ST_DATA;
                              bit_cnt <= 7'd31;
                           end
                           default: begin
                              state     <= ST_DONE;
                              flash_csn <= 1'b1;
                              ack_r     <= 1'b1;
                              // first byte received sits in rx_sr[31:24]
                              data_r    <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
                           end
                        endcase
                     end
                  end
               end
            end

            ST_DONE: begin
               if (CS_HIGH_CYCLES > 1) begin
                  state   <= ST_CS_GAP;
                  gap_cnt <= GAP_LOAD;
               end else begin
                  state  <= ST_IDLE;
                  busy_r <= 1'b0;
               end
            end

            ST_CS_GAP: begin
               if (gap_cnt == '0) begin
                  state  <= ST_IDLE;
                  busy_r <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
